// File: rtl/q_update_ctrl_if.sv
// Agent request/response and Q-table RAM signals of the Q-learning update controller.
// Pure wiring, no latency.
// Handshake is valid/ready on the agent side; the RAM side uses strobes plus a read-valid pulse.
interface q_update_ctrl_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int STATES_WIDTH  = 4,
  parameter int ACTIONS       = 4,
  parameter int ACTIONS_WIDTH = 2
);
  // Agent side
  logic                            i_upd_valid;
  logic                            o_upd_ready;
  logic [STATES_WIDTH-1:0]         i_st;
  logic [STATES_WIDTH-1:0]         i_next_st;
  logic [ACTIONS_WIDTH-1:0]        i_at;
  logic [DATA_WIDTH-1:0]           i_reward;
  logic                            i_dump;
  logic                            o_done;
  logic [DATA_WIDTH-1:0]           o_q_new;
  logic [ACTIONS_WIDTH-1:0]        o_best_action;
  // RAM side
  logic                            o_re;
  logic                            o_we;
  logic                            o_write_file_en;
  logic [STATES_WIDTH-1:0]         o_st;
  logic [STATES_WIDTH-1:0]         o_next_st;
  logic [ACTIONS_WIDTH-1:0]        o_at;
  logic [DATA_WIDTH-1:0]           o_data;
  logic [DATA_WIDTH-1:0]           i_q;
  logic [DATA_WIDTH*ACTIONS-1:0]   i_next_q;
  logic                            i_valid;

  // Controller side
  modport slave (
    input  i_upd_valid, i_st, i_next_st, i_at, i_reward, i_dump, i_q, i_next_q, i_valid,
    output o_upd_ready, o_done, o_q_new, o_best_action,
    output o_re, o_we, o_write_file_en, o_st, o_next_st, o_at, o_data
  );

  // Agent/RAM environment side
  modport master (
    output i_upd_valid, i_st, i_next_st, i_at, i_reward, i_dump, i_q, i_next_q, i_valid,
    input  o_upd_ready, o_done, o_q_new, o_best_action,
    input  o_re, o_we, o_write_file_en, o_st, o_next_st, o_at, o_data
  );
endinterface

// File: rtl/q_update_ctrl.sv
// One Q-learning update per request: read Q(s,a) and next row, argmax scan, fixed-point update, write back.
// Latency: accept at cycle 0, o_re at 1, o_we at 5+ACTIONS, o_done at 6+ACTIONS (RAM answering 2 cycles after o_re).
// Backpressure: o_upd_ready is high only in IDLE; WAIT stalls indefinitely for i_valid.
module q_update_ctrl #(
  parameter int DATA_WIDTH    = 16,
  parameter int STATES        = 16,
  parameter int STATES_WIDTH  = 4,
  parameter int ACTIONS       = 4,
  parameter int ACTIONS_WIDTH = 2,
  parameter int ALPHA_SHIFT   = 2,
  parameter int GAMMA_SHIFT   = 3
) (
  input logic            clk,
  input logic            rst,
  q_update_ctrl_if.slave bus
);
  localparam int W  = DATA_WIDTH + 2;
  localparam int RW = DATA_WIDTH * ACTIONS;
  localparam logic [ACTIONS_WIDTH-1:0] LAST_ACT = ACTIONS_WIDTH'(ACTIONS - 1);
  localparam logic signed [W-1:0] SAT_MAX = (W'(1) <<< (DATA_WIDTH - 1)) - W'(1);
  localparam logic signed [W-1:0] SAT_MIN = -(W'(1) <<< (DATA_WIDTH - 1));

  if (STATES > (1 << STATES_WIDTH)) begin : g_bad_states
    $error("STATES does not fit in STATES_WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_MAX, S_CALC, S_WRITE, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic                           ready_q, ready_d;
  logic                           re_q, re_d, we_q, we_d, done_q, done_d, wfe_q, wfe_d;
  logic                           pend_q, pend_d;
  logic [STATES_WIDTH-1:0]        st_q, st_d, nst_q, nst_d;
  logic [ACTIONS_WIDTH-1:0]       at_q, at_d, cnt_q, cnt_d, arg_q, arg_d, best_q, best_d;
  logic signed [DATA_WIDTH-1:0]   r_q, r_d, q_q, q_d, max_q, max_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [DATA_WIDTH-1:0]          data_q, data_d, q_new_q, q_new_d;
  logic                           accept, drain;
  logic signed [DATA_WIDTH-1:0]   cur_val;
  logic signed [W-1:0]            max_x, q_x, r_x, g_w, tgt_w, td_w, sum_w;
  logic [DATA_WIDTH-1:0]          q_sat;

  assign accept  = bus.i_upd_valid && ready_q;
  assign cur_val = row_q[DATA_WIDTH*(ACTIONS-1-int'(cnt_q)) +: DATA_WIDTH];

  // Fixed-point update on sign-extended operands; shifts are arithmetic (floor)
  assign max_x = {{2{max_q[DATA_WIDTH-1]}}, max_q};
  assign q_x   = {{2{q_q[DATA_WIDTH-1]}}, q_q};
  assign r_x   = {{2{r_q[DATA_WIDTH-1]}}, r_q};
  assign g_w   = max_x - (max_x >>> GAMMA_SHIFT);
  assign tgt_w = r_x + g_w;
  assign td_w  = tgt_w - q_x;
  assign sum_w = q_x + (td_w >>> ALPHA_SHIFT);

  // Clamp the widened result back into the signed DATA_WIDTH range
  always_comb begin
    q_sat = sum_w[DATA_WIDTH-1:0];
    if (sum_w > SAT_MAX)      q_sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (sum_w < SAT_MIN) q_sat = SAT_MIN[DATA_WIDTH-1:0];
  end

  // Next-state logic for the FSM, datapath registers, dump tracking and strobes
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    nst_d   = nst_q;
    at_d    = at_q;
    r_d     = r_q;
    q_d     = q_q;
    row_d   = row_q;
    max_d   = max_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    q_new_d = q_new_q;
    best_d  = best_q;
    pend_d  = pend_q;
    wfe_d   = 1'b0;
    drain   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          st_d    = bus.i_st;
          nst_d   = bus.i_next_st;
          at_d    = bus.i_at;
          r_d     = bus.i_reward;
          state_d = S_READ;
          // A dump arriving with an accepted update waits for that update to finish
          if (bus.i_dump) pend_d = 1'b1;
        end else if (bus.i_dump) begin
          wfe_d = 1'b1;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_valid) begin
          q_d     = bus.i_q;
          row_d   = bus.i_next_q;
          max_d   = bus.i_next_q[RW-1 -: DATA_WIDTH];
          arg_d   = '0;
          cnt_d   = '0;
          state_d = S_MAX;
        end
      end
      S_MAX: begin
        // Strictly greater keeps the lowest index on ties
        if (cur_val > max_q) begin
          max_d = cur_val;
          arg_d = cnt_q;
        end
        if (cnt_q == LAST_ACT) state_d = S_CALC;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      S_CALC: begin
        data_d  = q_sat;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        q_new_d = data_q;
        best_d  = arg_q;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.i_dump) pend_d = 1'b1;
    // Pending dump goes out in the first IDLE cycle, which then refuses new updates
    if (state_q == S_DONE && pend_d) begin
      wfe_d  = 1'b1;
      pend_d = 1'b0;
      drain  = 1'b1;
    end
    re_d    = (state_d == S_READ);
    we_d    = (state_d == S_WRITE);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE) && !drain;
  end

  // Single register stage for FSM state, datapath and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      wfe_q   <= 1'b0;
      pend_q  <= 1'b0;
      st_q    <= '0;
      nst_q   <= '0;
      at_q    <= '0;
      r_q     <= '0;
      q_q     <= '0;
      row_q   <= '0;
      max_q   <= '0;
      arg_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      q_new_q <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      re_q    <= re_d;
      we_q    <= we_d;
      done_q  <= done_d;
      wfe_q   <= wfe_d;
      pend_q  <= pend_d;
      st_q    <= st_d;
      nst_q   <= nst_d;
      at_q    <= at_d;
      r_q     <= r_d;
      q_q     <= q_d;
      row_q   <= row_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      q_new_q <= q_new_d;
      best_q  <= best_d;
    end
  end

  assign bus.o_upd_ready     = ready_q;
  assign bus.o_re            = re_q;
  assign bus.o_we            = we_q;
  assign bus.o_done          = done_q;
  assign bus.o_write_file_en = wfe_q;
  assign bus.o_st            = st_q;
  assign bus.o_next_st       = nst_q;
  assign bus.o_at            = at_q;
  assign bus.o_data          = data_q;
  assign bus.o_q_new         = q_new_q;
  assign bus.o_best_action   = best_q;
endmodule

// File: tb/tb_q_update_ctrl.sv
// Directed bench for q_update_ctrl: one task per scenario, inline checks against hand-computed values.
module tb_q_update_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail   = 0;

  q_update_ctrl_if bus ();
  q_update_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Results recorded by run_update (cycle numbers relative to accept = 0)
  int          re_cyc, we_cyc, done_cyc, re_cnt, we_cnt, wfe_cnt;
  logic        timed_out;
  logic [15:0] we_data, done_qnew;
  logic [3:0]  we_st, we_nst;
  logic [1:0]  we_at, done_best;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.i_upd_valid = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_dump      = 1'b0;
  endtask

  // Drives one update and plays the RAM (i_valid two cycles after o_re); returns at the o_done negedge
  task automatic run_update(input logic [3:0] st, input logic [1:0] at, input logic [3:0] nst,
                            input logic [15:0] r, input logic [15:0] q, input logic [63:0] row,
                            input int dump_at, input int dump_len);
    re_cyc = -1; we_cyc = -1; done_cyc = -1; re_cnt = 0; we_cnt = 0; wfe_cnt = 0;
    we_data = 'x; done_qnew = 'x; we_st = 'x; we_nst = 'x; we_at = 'x; done_best = 'x;
    timed_out = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.o_upd_ready) begin timed_out = 1'b0; break; end
    end
    if (!timed_out) begin
      timed_out = 1'b1;
      bus.i_st = st; bus.i_at = at; bus.i_next_st = nst; bus.i_reward = r;
      bus.i_q = q; bus.i_next_q = row;
      for (int n = 0; n < 40; n++) begin
        if (n > 0) begin
          @(negedge clk);
          if (bus.o_re) begin re_cnt++; if (re_cyc < 0) re_cyc = n; end
          if (bus.o_we) begin
            we_cnt++; we_cyc = n; we_data = bus.o_data;
            we_st = bus.o_st; we_at = bus.o_at; we_nst = bus.o_next_st;
          end
          if (bus.o_write_file_en) wfe_cnt++;
          if (bus.o_done) begin
            done_cyc = n; done_qnew = bus.o_q_new; done_best = bus.o_best_action;
          end
        end
        bus.i_upd_valid = (n == 0);
        bus.i_valid     = (re_cyc >= 0) && (n == re_cyc + 2);
        bus.i_dump      = (n >= dump_at) && (n < dump_at + dump_len);
        if (done_cyc >= 0) begin
          timed_out = 1'b0;
          idle_inputs();
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.i_st = '0; bus.i_at = '0; bus.i_next_st = '0; bus.i_reward = '0;
    bus.i_q = '0; bus.i_next_q = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.o_upd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.o_upd_ready); end
    n_checks++; if ({bus.o_re, bus.o_we, bus.o_write_file_en, bus.o_done} !== 4'b0) begin n_fail++;
      $display("FAIL reset_strobes: got %b expected 0000", {bus.o_re, bus.o_we, bus.o_write_file_en, bus.o_done}); end
    n_checks++; if ({bus.o_data, bus.o_q_new} !== 32'h0) begin n_fail++;
      $display("FAIL reset_data: got %h expected 0", {bus.o_data, bus.o_q_new}); end
    n_checks++; if ({bus.o_st, bus.o_next_st, bus.o_at, bus.o_best_action} !== 12'h0) begin n_fail++;
      $display("FAIL reset_addr: got %h expected 0", {bus.o_st, bus.o_next_st, bus.o_at, bus.o_best_action}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.o_upd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b expected 1", bus.o_upd_ready); end
  endtask

  task automatic test_nominal();
    run_update(4'd3, 2'd2, 4'd7, 16'h0100, 16'h0100, {16'h0080, 16'h0200, 16'h0180, 16'hFF00}, -10, 0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL nominal_timeout: got %b expected 0", timed_out); end
    n_checks++; if (re_cyc !== 1 || re_cnt !== 1) begin n_fail++; $display("FAIL nominal_re: cycle %0d count %0d expected cycle 1 count 1", re_cyc, re_cnt); end
    n_checks++; if (we_cyc !== 9 || we_cnt !== 1) begin n_fail++; $display("FAIL nominal_we: cycle %0d count %0d expected cycle 9 count 1", we_cyc, we_cnt); end
    n_checks++; if (done_cyc !== 10) begin n_fail++; $display("FAIL nominal_done_cycle: got %0d expected 10", done_cyc); end
    n_checks++; if (we_data !== 16'h0170) begin n_fail++; $display("FAIL nominal_data: got %h expected 0170", we_data); end
    n_checks++; if ({we_st, we_at, we_nst} !== {4'd3, 2'd2, 4'd7}) begin n_fail++;
      $display("FAIL nominal_addr: got st=%0d at=%0d nst=%0d expected 3 2 7", we_st, we_at, we_nst); end
    n_checks++; if (done_qnew !== 16'h0170 || done_best !== 2'd1) begin n_fail++;
      $display("FAIL nominal_result: got q_new=%h best=%0d expected 0170 1", done_qnew, done_best); end
    @(negedge clk);
    n_checks++; if (bus.o_done !== 1'b0 || bus.o_q_new !== 16'h0170 || bus.o_best_action !== 2'd1) begin n_fail++;
      $display("FAIL nominal_hold: got done=%b q_new=%h best=%0d expected 0 0170 1", bus.o_done, bus.o_q_new, bus.o_best_action); end
  endtask

  task automatic test_saturation();
    run_update(4'd1, 2'd0, 4'd2, 16'h7F00, 16'h7F00, {4{16'h7F00}}, -10, 0);
    n_checks++; if (timed_out !== 1'b0 || we_data !== 16'h7FFF) begin n_fail++;
      $display("FAIL sat_pos: got %h (timeout %b) expected 7FFF", we_data, timed_out); end
    run_update(4'd4, 2'd3, 4'd5, 16'hFF00, 16'h0000, 64'h0, -10, 0);
    n_checks++; if (timed_out !== 1'b0 || we_data !== 16'hFFC0) begin n_fail++;
      $display("FAIL neg_reward: got %h (timeout %b) expected FFC0", we_data, timed_out); end
  endtask

  task automatic test_ties();
    run_update(4'd0, 2'd1, 4'd9, 16'h0000, 16'h0000, {4{16'h0040}}, -10, 0);
    n_checks++; if (done_best !== 2'd0 || we_data !== 16'h000E) begin n_fail++;
      $display("FAIL tie_equal: got best=%0d data=%h expected 0 000E", done_best, we_data); end
    run_update(4'd0, 2'd1, 4'd9, 16'h0000, 16'h0000, {16'h8000, 16'h8000, 16'h8001, 16'h8000}, -10, 0);
    n_checks++; if (done_best !== 2'd2 || we_data !== 16'hE400) begin n_fail++;
      $display("FAIL tie_negative: got best=%0d data=%h expected 2 E400", done_best, we_data); end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int re_c = -100;
    int done_n = 0;
    bus.i_st = 4'd2; bus.i_at = 2'd1; bus.i_next_st = 4'd3; bus.i_reward = 16'h0100;
    bus.i_q = 16'h0100; bus.i_next_q = {16'h0080, 16'h0200, 16'h0180, 16'hFF00};
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      if (bus.o_re) re_c = n;
      if (bus.o_done) done_n++;
      bus.i_upd_valid = (n < 30);
      bus.i_valid     = (n == re_c + 2);
      if (bus.i_upd_valid && bus.o_upd_ready) accepts.push_back(n);
    end
    idle_inputs();
    n_checks++; if (accepts.size() !== 3) begin n_fail++; $display("FAIL b2b_accepts: got %0d expected 3", accepts.size()); end
    if (accepts.size() == 3) begin
      n_checks++; if (accepts[1] - accepts[0] !== 11 || accepts[2] - accepts[1] !== 11) begin n_fail++;
        $display("FAIL b2b_spacing: got %0d %0d expected 11 11", accepts[1] - accepts[0], accepts[2] - accepts[1]); end
    end
    n_checks++; if (done_n !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", done_n); end
  endtask

  task automatic test_valid_in_idle();
    int bad = 0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (bus.o_upd_ready !== 1'b1 || bus.o_re || bus.o_we || bus.o_done) bad++;
      @(negedge clk);
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL valid_in_idle: %0d disturbed cycles expected 0", bad); end
  endtask

  task automatic test_dump_idle();
    int pulses = 0;
    @(negedge clk);
    bus.i_dump = 1'b1;
    @(negedge clk);
    bus.i_dump = 1'b0;
    n_checks++; if (bus.o_write_file_en !== 1'b1) begin n_fail++; $display("FAIL dump_idle_pulse: got %b expected 1", bus.o_write_file_en); end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.o_write_file_en) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL dump_idle_single: got %0d extra pulses expected 0", pulses); end
  endtask

  task automatic test_dump_pending();
    run_update(4'd6, 2'd0, 4'd1, 16'h0100, 16'h0100, {16'h0080, 16'h0200, 16'h0180, 16'hFF00}, 5, 2);
    n_checks++; if (timed_out !== 1'b0 || wfe_cnt !== 0) begin n_fail++;
      $display("FAIL dump_pending_early: got %0d pulses (timeout %b) expected 0", wfe_cnt, timed_out); end
    @(negedge clk);
    n_checks++; if (bus.o_write_file_en !== 1'b1 || bus.o_upd_ready !== 1'b0) begin n_fail++;
      $display("FAIL dump_pending_issue: got wfe=%b ready=%b expected 1 0", bus.o_write_file_en, bus.o_upd_ready); end
    @(negedge clk);
    n_checks++; if (bus.o_write_file_en !== 1'b0 || bus.o_upd_ready !== 1'b1) begin n_fail++;
      $display("FAIL dump_pending_after: got wfe=%b ready=%b expected 0 1", bus.o_write_file_en, bus.o_upd_ready); end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    int waited = 0;
    bus.i_st = 4'd8; bus.i_at = 2'd3; bus.i_next_st = 4'd9; bus.i_reward = 16'h0100;
    bus.i_q = 16'h0100; bus.i_next_q = {16'h0080, 16'h0200, 16'h0180, 16'hFF00};
    while (bus.o_upd_ready !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
    bus.i_upd_valid = 1'b1;
    @(negedge clk);
    bus.i_upd_valid = 1'b0;
    n_checks++; if (bus.o_re !== 1'b1) begin n_fail++; $display("FAIL midrst_re: got %b expected 1", bus.o_re); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b1;
    n_checks++; if ({bus.o_upd_ready, bus.o_re, bus.o_we, bus.o_done, bus.o_write_file_en} !== 5'b0) begin n_fail++;
      $display("FAIL midrst_strobes: got %b expected 00000", {bus.o_upd_ready, bus.o_re, bus.o_we, bus.o_done, bus.o_write_file_en}); end
    n_checks++; if ({bus.o_data, bus.o_q_new, bus.o_st, bus.o_at, bus.o_next_st, bus.o_best_action} !== 44'h0) begin n_fail++;
      $display("FAIL midrst_values: got %h expected 0", {bus.o_data, bus.o_q_new, bus.o_st, bus.o_at, bus.o_next_st, bus.o_best_action}); end
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.o_we || bus.o_done) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d write/done cycles expected 0", late); end
    run_update(4'd8, 2'd3, 4'd9, 16'h0100, 16'h0100, {16'h0080, 16'h0200, 16'h0180, 16'hFF00}, -10, 0);
    n_checks++; if (timed_out !== 1'b0 || done_cyc !== 10 || we_data !== 16'h0170) begin n_fail++;
      $display("FAIL midrst_recover: got done=%0d data=%h (timeout %b) expected 10 0170", done_cyc, we_data, timed_out); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_ties();
    test_back_to_back();
    test_valid_in_idle();
    test_dump_idle();
    test_dump_pending();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
